// File: rtl/collision_score_unit.sv
// Per-frame collision latching and vsync-committed BCD score / lives bookkeeping.
// Collisions seen during a frame are latched, then applied once at the vsync assertion edge.
module collision_score_unit #(
    parameter int unsigned                  NUM_ROWS         = 5,
    parameter int unsigned                  NUM_COLUMNS      = 8,
    parameter int unsigned                  SCORE_DIGITS     = 4,
    parameter int unsigned                  LIVES_W          = 2,
    parameter int unsigned                  START_LIVES      = 3,
    parameter logic [7:0]                   PTS_HI           = 8'h30,
    parameter logic [7:0]                   PTS_MID          = 8'h20,
    parameter logic [7:0]                   PTS_LO           = 8'h10,
    parameter logic [4*SCORE_DIGITS-1:0]    EXTRA_LIFE_AT    = 16'h1000,
    parameter bit                           VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             vsync,
    input  logic                             display_on,
    input  logic                             game_active,
    input  logic                             reset_game,
    input  logic                             laser_gfx,
    input  logic                             alien_pixel,
    input  logic [$clog2(NUM_ROWS)-1:0]      alien_row,
    input  logic [$clog2(NUM_COLUMNS)-1:0]   alien_col,
    input  logic                             bomb_gfx,
    input  logic                             cannon_gfx,
    output logic                             hit_alien,
    output logic [$clog2(NUM_ROWS)-1:0]      hit_row,
    output logic [$clog2(NUM_COLUMNS)-1:0]   hit_col,
    output logic                             player_hit,
    output logic                             extra_life,
    output logic [4*SCORE_DIGITS-1:0]        score,
    output logic [LIVES_W-1:0]               lives,
    output logic                             game_over
);

    localparam int unsigned ROW_W     = $clog2(NUM_ROWS);
    localparam int unsigned COL_W     = $clog2(NUM_COLUMNS);
    localparam int unsigned SCORE_W   = 4 * SCORE_DIGITS;
    localparam int unsigned LW1       = LIVES_W + 1;
    localparam int unsigned MAX_LIVES = (2 ** LIVES_W) - 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_DIGITS{4'h9}};

    // Digit-serial BCD add; MSB of the result is the carry out of the top digit
    function automatic logic [SCORE_W:0] bcd_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
        logic [SCORE_W-1:0] r;
        logic               c;
        logic [4:0]         d;
        r = '0;
        c = 1'b0;
        for (int i = 0; i < int'(SCORE_DIGITS); i++) begin
            d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + 5'(c);
            if (d > 5'd9) begin
                r[4*i +: 4] = 4'(d - 5'd10);
                c = 1'b1;
            end else begin
                r[4*i +: 4] = d[3:0];
                c = 1'b0;
            end
        end
        return {c, r};
    endfunction

    logic               vsync_act;
    logic               vsync_q;
    logic               commit;
    logic               latch_en;
    logic               alien_lat;
    logic               bomb_lat;
    logic [ROW_W-1:0]   lat_row;
    logic [COL_W-1:0]   lat_col;
    logic               bonus_armed;

    logic [SCORE_W-1:0] pts_c;
    logic [SCORE_W:0]   sum_c;
    logic [SCORE_W-1:0] score_new_c;
    logic               bonus_c;
    logic               lose_c;
    logic [LIVES_W:0]   lives_sum_c;
    logic [LIVES_W-1:0] lives_new_c;

    assign vsync_act = VSYNC_ACTIVE_LOW ? ~vsync : vsync;
    assign commit    = vsync_act & ~vsync_q;
    assign latch_en  = display_on & game_active & ~game_over;

    // Commit-time arithmetic: points lookup, saturating BCD add, bonus and net lives
    always_comb begin
        pts_c       = SCORE_W'(PTS_LO);
        score_new_c = score;
        bonus_c     = 1'b0;
        lose_c      = 1'b0;
        lives_sum_c = '0;
        lives_new_c = lives;

        if (lat_row == ROW_W'(0)) begin
            pts_c = SCORE_W'(PTS_HI);
        end else if (lat_row <= ROW_W'(2)) begin
            pts_c = SCORE_W'(PTS_MID);
        end
        sum_c = bcd_add(score, pts_c);

        if (alien_lat) begin
            score_new_c = sum_c[SCORE_W] ? SCORE_MAX : sum_c[SCORE_W-1:0];
        end

        bonus_c = (EXTRA_LIFE_AT != '0) && bonus_armed && alien_lat &&
                  (score < EXTRA_LIFE_AT) && (score_new_c >= EXTRA_LIFE_AT);
        lose_c  = bomb_lat && (lives != '0);

        lives_sum_c = {1'b0, lives} + LW1'(bonus_c) - LW1'(lose_c);
        if (lives_sum_c > LW1'(MAX_LIVES)) begin
            lives_new_c = LIVES_W'(MAX_LIVES);
        end else begin
            lives_new_c = lives_sum_c[LIVES_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q     <= 1'b0;
            alien_lat   <= 1'b0;
            bomb_lat    <= 1'b0;
            lat_row     <= '0;
            lat_col     <= '0;
            bonus_armed <= 1'b1;
            hit_alien   <= 1'b0;
            hit_row     <= '0;
            hit_col     <= '0;
            player_hit  <= 1'b0;
            extra_life  <= 1'b0;
            score       <= '0;
            lives       <= LIVES_W'(START_LIVES);
            game_over   <= 1'b0;
        end else begin
            vsync_q    <= vsync_act;
            hit_alien  <= 1'b0;
            player_hit <= 1'b0;
            extra_life <= 1'b0;

            if (reset_game) begin
                alien_lat   <= 1'b0;
                bomb_lat    <= 1'b0;
                bonus_armed <= 1'b1;
                score       <= '0;
                lives       <= LIVES_W'(START_LIVES);
                game_over   <= 1'b0;
            end else if (commit) begin
                alien_lat <= 1'b0;
                bomb_lat  <= 1'b0;
                if (!game_over) begin
                    score      <= score_new_c;
                    lives      <= lives_new_c;
                    game_over  <= (lives_new_c == '0);
                    hit_alien  <= alien_lat;
                    player_hit <= lose_c;
                    extra_life <= bonus_c;
                    if (alien_lat) begin
                        hit_row <= lat_row;
                        hit_col <= lat_col;
                    end
                    if (bonus_c) begin
                        bonus_armed <= 1'b0;
                    end
                end
            end else begin
                // Only the first laser/alien overlap of a frame is kept
                if (latch_en && laser_gfx && alien_pixel && !alien_lat) begin
                    alien_lat <= 1'b1;
                    lat_row   <= alien_row;
                    lat_col   <= alien_col;
                end
                if (latch_en && bomb_gfx && cannon_gfx) begin
                    bomb_lat <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_collision_score_unit.sv
// Directed bench for collision_score_unit: driver queues expected commit results,
// a monitor compares DUT outputs on the cycle after each vsync commit.
module tb_collision_score_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b1;
    logic        display_on = 1'b0;
    logic        game_active = 1'b0;
    logic        reset_game = 1'b0;
    logic        laser_gfx = 1'b0;
    logic        alien_pixel = 1'b0;
    logic [2:0]  alien_row = '0;
    logic [2:0]  alien_col = '0;
    logic        bomb_gfx = 1'b0;
    logic        cannon_gfx = 1'b0;
    logic        hit_alien;
    logic [2:0]  hit_row;
    logic [2:0]  hit_col;
    logic        player_hit;
    logic        extra_life;
    logic [15:0] score;
    logic [1:0]  lives;
    logic        game_over;

    collision_score_unit dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .display_on(display_on),
        .game_active(game_active), .reset_game(reset_game), .laser_gfx(laser_gfx),
        .alien_pixel(alien_pixel), .alien_row(alien_row), .alien_col(alien_col),
        .bomb_gfx(bomb_gfx), .cannon_gfx(cannon_gfx), .hit_alien(hit_alien),
        .hit_row(hit_row), .hit_col(hit_col), .player_hit(player_hit),
        .extra_life(extra_life), .score(score), .lives(lives), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hit;
        logic [2:0]  row;
        logic [2:0]  col;
        logic        ph;
        logic        el;
        logic [15:0] score;
        logic [1:0]  lives;
        logic        go;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   n_commit = 0;
    int   s_model = 0;
    bit   armed_model = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          t;
        t = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic exp_t mk(input bit hit, input int row, input int col, input bit ph,
                                input bit el, input logic [15:0] sc, input int lv, input bit go);
        exp_t e;
        e.hit = hit; e.row = 3'(row); e.col = 3'(col); e.ph = ph; e.el = el;
        e.score = sc; e.lives = 2'(lv); e.go = go;
        return e;
    endfunction

    // Monitor: commit happens on the posedge after vsync goes active; results show one cycle later
    initial begin
        exp_t e;
        forever begin
            @(negedge vsync);
            @(posedge clk);
            @(negedge clk);
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL commit_unexpected actual=output expected=none");
            end else begin
                e = q.pop_front();
                chk($sformatf("hit_alien[%0d]", n_commit), 32'(hit_alien), 32'(e.hit));
                chk($sformatf("hit_row[%0d]", n_commit), 32'(hit_row), 32'(e.row));
                chk($sformatf("hit_col[%0d]", n_commit), 32'(hit_col), 32'(e.col));
                chk($sformatf("player_hit[%0d]", n_commit), 32'(player_hit), 32'(e.ph));
                chk($sformatf("extra_life[%0d]", n_commit), 32'(extra_life), 32'(e.el));
                chk($sformatf("score[%0d]", n_commit), 32'(score), 32'(e.score));
                chk($sformatf("lives[%0d]", n_commit), 32'(lives), 32'(e.lives));
                chk($sformatf("game_over[%0d]", n_commit), 32'(game_over), 32'(e.go));
            end
            @(negedge clk);
            chk($sformatf("pulse_len[%0d]", n_commit), 32'({hit_alien, player_hit, extra_life}), 32'(0));
            n_commit++;
        end
    end

    task automatic overlap(input bit a, input bit b, input int row, input int col, input bit ga = 1'b1);
        @(negedge clk);
        display_on = 1'b1; game_active = ga;
        laser_gfx = a; alien_pixel = a; alien_row = 3'(row); alien_col = 3'(col);
        bomb_gfx = b; cannon_gfx = b;
        @(negedge clk);
        display_on = 1'b0; laser_gfx = 1'b0; alien_pixel = 1'b0;
        bomb_gfx = 1'b0; cannon_gfx = 1'b0;
    endtask

    task automatic commit(input exp_t e, input bit rg = 1'b0);
        @(negedge clk);
        vsync = 1'b0;
        reset_game = rg;
        q.push_back(e);
        @(negedge clk);
        reset_game = 1'b0;
        repeat (2) @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
    endtask

    task automatic restart_game();
        @(negedge clk);
        reset_game = 1'b1;
        @(negedge clk);
        reset_game = 1'b0;
        s_model = 0;
        armed_model = 1'b1;
    endtask

    // Row-0 kills at a fixed column with lives held at 3 (bonus saturates)
    task automatic kill_loop(input int n, input int col);
        int  old;
        bit  el;
        for (int i = 0; i < n; i++) begin
            old = s_model;
            s_model = (s_model + 30 > 9999) ? 9999 : s_model + 30;
            el = armed_model && (old < 1000) && (s_model >= 1000);
            if (el) armed_model = 1'b0;
            overlap(1'b1, 1'b0, 0, col);
            commit(mk(1'b1, 0, col, 1'b0, el, to_bcd(s_model), 3, 1'b0));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int wait_cyc;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_score", 32'(score), 32'h0);
        chk("reset_lives", 32'(lives), 32'd3);
        chk("reset_game_over", 32'(game_over), 32'd0);
        chk("reset_hit_row", 32'(hit_row), 32'd0);
        chk("reset_hit_col", 32'(hit_col), 32'd0);
        chk("reset_pulses", 32'({hit_alien, player_hit, extra_life}), 32'd0);

        overlap(1'b1, 1'b0, 0, 5);
        commit(mk(1'b1, 0, 5, 1'b0, 1'b0, 16'h0030, 3, 1'b0));

        overlap(1'b1, 1'b0, 4, 2);
        overlap(1'b1, 1'b0, 1, 7);
        commit(mk(1'b1, 4, 2, 1'b0, 1'b0, 16'h0040, 3, 1'b0));

        // 0990 + row-0 kill with a bomb hit in the same commit: net lives unchanged
        restart_game();
        kill_loop(33, 3);
        overlap(1'b1, 1'b1, 0, 6);
        commit(mk(1'b1, 0, 6, 1'b1, 1'b1, 16'h1020, 3, 1'b0));

        // Same threshold crossing without a bomb: lives saturate at 3
        restart_game();
        kill_loop(33, 3);
        overlap(1'b1, 1'b0, 0, 6);
        commit(mk(1'b1, 0, 6, 1'b0, 1'b1, 16'h1020, 3, 1'b0));

        overlap(1'b0, 1'b1, 0, 0);
        commit(mk(1'b0, 0, 6, 1'b1, 1'b0, 16'h1020, 2, 1'b0));
        overlap(1'b0, 1'b1, 0, 0);
        commit(mk(1'b0, 0, 6, 1'b1, 1'b0, 16'h1020, 1, 1'b0));
        overlap(1'b0, 1'b1, 0, 0);
        commit(mk(1'b0, 0, 6, 1'b1, 1'b0, 16'h1020, 0, 1'b1));
        overlap(1'b1, 1'b1, 2, 2);
        commit(mk(1'b0, 0, 6, 1'b0, 1'b0, 16'h1020, 0, 1'b1));

        // reset_game coinciding with the commit cycle wins over both latches
        restart_game();
        overlap(1'b1, 1'b1, 3, 3);
        commit(mk(1'b0, 0, 6, 1'b0, 1'b0, 16'h0000, 3, 1'b0), 1'b1);
        commit(mk(1'b0, 0, 6, 1'b0, 1'b0, 16'h0000, 3, 1'b0));
        overlap(1'b1, 1'b0, 2, 4);
        commit(mk(1'b1, 2, 4, 1'b0, 1'b0, 16'h0020, 3, 1'b0));

        // Run up to 9990, then one more kill saturates at 9999
        restart_game();
        kill_loop(333, 1);
        overlap(1'b1, 1'b0, 0, 1);
        commit(mk(1'b1, 0, 1, 1'b0, 1'b0, 16'h9999, 3, 1'b0));
        overlap(1'b1, 1'b1, 2, 4, 1'b0);
        commit(mk(1'b0, 0, 1, 1'b0, 1'b0, 16'h9999, 3, 1'b0));

        // Async reset mid-frame drops latched events
        overlap(1'b1, 1'b1, 1, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        commit(mk(1'b0, 0, 0, 1'b0, 1'b0, 16'h0000, 3, 1'b0));

        wait_cyc = 0;
        while (q.size() != 0 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d pending expected=0", q.size());
        end
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/collision_score_unit.md
Name: collision_score_unit

Overview:
Per-frame collision detector and score/lives keeper for the game core. It watches the pixel-rate graphics flags and latches two collisions per frame: laser against alien, and bomb against cannon. At each vsync assertion it commits the latched events, adding BCD score per alien row and decrementing lives. It feeds `hit_alien` back to the laser and formation blocks, and drives `score`, `lives` and `game_over` to the HUD and the state machine.

Parameters:
NUM_ROWS, 5, alien formation rows
NUM_COLUMNS, 8, alien formation columns
SCORE_DIGITS, 4, BCD digits of score (score width 4*SCORE_DIGITS)
LIVES_W, 2, lives counter width; max lives 2**LIVES_W-1
START_LIVES, 3, lives after reset/reset_game
PTS_HI, 8'h30, 2-digit BCD points for row 0
PTS_MID, 8'h20, BCD points for rows 1..2
PTS_LO, 8'h10, BCD points for rows >=3
EXTRA_LIFE_AT, 16'h1000, BCD score threshold for one bonus life per game (0 = disabled)
VSYNC_ACTIVE_LOW, 1, vsync polarity

Ports:
clk  in  1  pixel clock (same domain as hvsync generator)
rst_n  in  1  asynchronous active-low reset
vsync  in  1  frame sync from hvsync generator
display_on  in  1  visible-area flag
game_active  in  1  high in playing state; collisions latched only when high
reset_game  in  1  sync pulse: restart score/lives
laser_gfx  in  1  laser pixel
alien_pixel  in  1  alien pixel
alien_row  in  $clog2(NUM_ROWS)  row of alien under beam
alien_col  in  $clog2(NUM_COLUMNS)  column of alien under beam
bomb_gfx  in  1  alien bomb pixel
cannon_gfx  in  1  cannon pixel
hit_alien  out  1  one-cycle commit pulse: alien destroyed
hit_row  out  $clog2(NUM_ROWS)  row of destroyed alien, held until next hit
hit_col  out  $clog2(NUM_COLUMNS)  column of destroyed alien, held
player_hit  out  1  one-cycle commit pulse: cannon hit
extra_life  out  1  one-cycle pulse when bonus life awarded
score  out  4*SCORE_DIGITS  BCD score
lives  out  LIVES_W  remaining lives
game_over  out  1  sticky: lives reached 0

Behaviour:
- Async reset: score=0, lives=START_LIVES, game_over=0, all pulses 0, hit_row/hit_col=0, latches cleared, bonus armed.
- Latch phase: alien latch sets on the first cycle with display_on & game_active & !game_over & laser_gfx & alien_pixel. Row/col are captured on that first cycle only; later overlaps in the same frame are ignored (one kill per frame). Bomb latch sets on display_on & game_active & !game_over & bomb_gfx & cannon_gfx.
- Commit: vsync is registered once. commit = vsync active & prev inactive. On the commit cycle, registers update and are visible the following cycle; pulses are high for exactly that one cycle. Both latches clear on commit.
- Score: if the alien latch is set, score += points(row) as BCD with per-digit carry in one cycle. Row 0 gives PTS_HI, rows 1..2 give PTS_MID, all other rows give PTS_LO. Score saturates at all-9s.
- Bonus: if EXTRA_LIFE_AT!=0, bonus is armed, old score<EXTRA_LIFE_AT and new score>=EXTRA_LIFE_AT (unsigned compare of BCD), then extra_life pulses, lives +1 saturating at max, and bonus disarms.
- Lives: if the bomb latch is set and lives>0, lives -1. With bonus and hit in the same commit, the net change is applied (no change). If the resulting lives==0, game_over=1 on the same update.
- Simultaneous alien kill and player death: the kill is still scored and hit_alien still pulses.
- While game_over=1: no latching, no commits change score/lives; pulses stay 0.
- reset_game has priority over commit in the same cycle: score=0, lives=START_LIVES, game_over=0, latches cleared, bonus re-armed, no pulses.
- rst_n asserted mid-frame discards latched events.

Test Plan:
- Laser/alien overlap at row 0 col 5 during frame, then vsync -> hit_alien pulse 1 cycle, hit_row=0, hit_col=5, score 0000->0030.
- Overlaps at row 4 then row 1 in the same frame -> single commit, +0010, hit_row=4.
- Score 0990 plus row-0 kill -> 1020, extra_life pulse, lives 3->3 if a bomb hit occurs in the same commit, else 3->4 saturates at 3 (LIVES_W=2).
- Bomb/cannon overlap with lives=1 -> player_hit pulse, lives=0, game_over=1; next frame's overlaps -> no change.
- reset_game on the commit cycle with both latches set -> score=0, lives=3, no pulses.
- Score 9990 plus row-0 kill -> 9999 (saturate); game_active=0 overlaps -> nothing committed.
